// File: rtl/wt_mult_pipe.sv
// Three-stage pipelined Wallace-tree multiplier: signed (Baugh-Wooley) or unsigned per transaction.
// Define WT_ACC_EN to add the acc_clr/acc ports and a running accumulator of transferred products.
module wt_mult_pipe #(
  parameter int A_W   = 8,
  parameter int B_W   = 16,
  parameter int P_W   = A_W + B_W,
  parameter int ACC_W = A_W + B_W + 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   p
`ifdef WT_ACC_EN
  ,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc
`endif
);

  // B_W partial-product rows plus one Baugh-Wooley correction row.
  localparam int N0  = B_W + 1;
  localparam int NG  = N0 / 5;
  localparam int NR  = N0 % 5;
  localparam int N1  = 2 * NG + ((NR < 3) ? NR : NR - 1);
  localparam int NC  = (N1 - 2) / 3;
  localparam int NR2 = (N1 - 2) % 3;

  localparam logic [P_W-1:0] ONE     = P_W'(1);
  localparam logic [P_W-1:0] BW_CORR = (ONE << (A_W - 1)) + (ONE << (B_W - 1)) + (ONE << (P_W - 1));

  if (A_W < 2 || B_W < 2 || P_W != A_W + B_W || ACC_W <= P_W) begin : g_param_check
    $error("wt_mult_pipe: illegal parameter combination");
  end

  // Returns {carry, sum}; carries wrap modulo 2^P_W, which is exact for the final product.
  function automatic logic [2*P_W-1:0] csa_3to2(input logic [P_W-1:0] x,
                                                input logic [P_W-1:0] y,
                                                input logic [P_W-1:0] z);
    logic [P_W-1:0] s;
    logic [P_W-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  function automatic logic [2*P_W-1:0] compressor_5to2(input logic [P_W-1:0] x0,
                                                       input logic [P_W-1:0] x1,
                                                       input logic [P_W-1:0] x2,
                                                       input logic [P_W-1:0] x3,
                                                       input logic [P_W-1:0] x4);
    logic [2*P_W-1:0] t;
    t = csa_3to2(x0, x1, x2);
    t = csa_3to2(t[P_W-1:0], t[2*P_W-1:P_W], x3);
    t = csa_3to2(t[P_W-1:0], t[2*P_W-1:P_W], x4);
    return t;
  endfunction

  logic           adv;
  logic           v1_d, v2_d, v3_d;
  logic           v1_q, v2_q, v3_q;
  logic [P_W-1:0] rows1_d [N1];
  logic [P_W-1:0] rows1_q [N1];
  logic [P_W-1:0] sum2_d, car2_d;
  logic [P_W-1:0] sum2_q, car2_q;
  logic [P_W-1:0] p_d, p_q;

  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign p         = p_q;

  // S1: partial products with Baugh-Wooley inversion, then one row of 5:2 compressors.
  always_comb begin : s1_comb
    logic [P_W-1:0]   pp [5*NG+5];
    logic [P_W-1:0]   r1 [2*NG+4];
    logic [2*P_W-1:0] t;
    logic             bit_v;
    // NOTE: every combinational variable gets a default before any conditional write, so no latch is inferred.
    for (int i = 0; i < 5*NG+5; i++) pp[i] = '0;
    for (int i = 0; i < 2*NG+4; i++) r1[i] = '0;
    t     = '0;
    bit_v = 1'b0;
    for (int i = 0; i < B_W; i++) begin
      for (int j = 0; j < A_W; j++) begin
        bit_v = a[j] & b[i];
        if (sgn && ((i == B_W - 1) != (j == A_W - 1))) bit_v = ~bit_v;
        pp[i][i+j] = bit_v;
      end
    end
    pp[B_W] = sgn ? BW_CORR : '0;
    for (int g = 0; g < NG; g++) begin
      t = compressor_5to2(pp[5*g], pp[5*g+1], pp[5*g+2], pp[5*g+3], pp[5*g+4]);
      r1[2*g]   = t[P_W-1:0];
      r1[2*g+1] = t[2*P_W-1:P_W];
    end
    if (NR >= 3) begin
      t = csa_3to2(pp[5*NG], pp[5*NG+1], pp[5*NG+2]);
      r1[2*NG]   = t[P_W-1:0];
      r1[2*NG+1] = t[2*P_W-1:P_W];
      if (NR == 4) r1[2*NG+2] = pp[5*NG+3];
    end else begin
      for (int k = 0; k < NR; k++) r1[2*NG+k] = pp[5*NG+k];
    end
    for (int i = 0; i < N1; i++) rows1_d[i] = r1[i];
  end

  // S2: fold the remaining rows into the running sum/carry pair.
  always_comb begin : s2_comb
    logic [P_W-1:0]   r2 [N1+3];
    logic [2*P_W-1:0] t;
    for (int i = 0; i < N1+3; i++) r2[i] = '0;
    for (int i = 0; i < N1; i++) r2[i] = rows1_q[i];
    t = {r2[1], r2[0]};
    for (int k = 0; k < NC; k++) begin
      t = compressor_5to2(t[P_W-1:0], t[2*P_W-1:P_W], r2[2+3*k], r2[3+3*k], r2[4+3*k]);
    end
    if (NR2 >= 1) t = csa_3to2(t[P_W-1:0], t[2*P_W-1:P_W], r2[2+3*NC]);
    if (NR2 == 2) t = csa_3to2(t[P_W-1:0], t[2*P_W-1:P_W], r2[3+3*NC]);
    sum2_d = t[P_W-1:0];
    car2_d = t[2*P_W-1:P_W];
  end

  always_comb begin
    v1_d = in_valid;
    v2_d = v1_q;
    v3_d = v2_q;
    p_d  = sum2_q + car2_q;
  end

  // The whole pipe advances as one; a stalled output freezes every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the pipeline arrays are a handful of flops, so they are cleared like any other register.
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      for (int i = 0; i < N1; i++) rows1_q[i] <= '0;
      sum2_q <= '0;
      car2_q <= '0;
      p_q    <= '0;
    end else if (adv) begin
      // NOTE: non-blocking updates let every stage read its predecessor's old value.
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      for (int i = 0; i < N1; i++) rows1_q[i] <= rows1_d[i];
      sum2_q <= sum2_d;
      car2_q <= car2_d;
      p_q    <= p_d;
    end
  end

`ifdef WT_ACC_EN
  logic             clr1_q, clr2_q, clr3_q;
  logic             sgn1_q, sgn2_q, sgn3_q;
  logic [ACC_W-1:0] acc_d, acc_q;

  always_comb begin
    acc_d = acc_q;
    if (v3_q && out_ready)
      acc_d = (clr3_q ? '0 : acc_q) + {{(ACC_W-P_W){sgn3_q & p_q[P_W-1]}}, p_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr1_q <= 1'b0;
      clr2_q <= 1'b0;
      clr3_q <= 1'b0;
      sgn1_q <= 1'b0;
      sgn2_q <= 1'b0;
      sgn3_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      if (adv) begin
        clr1_q <= acc_clr;
        clr2_q <= clr1_q;
        clr3_q <= clr2_q;
        sgn1_q <= sgn;
        sgn2_q <= sgn1_q;
        sgn3_q <= sgn2_q;
      end
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
`endif

endmodule

// File: tb/tb_wt_mult_pipe.sv
// Randomised and directed bench for wt_mult_pipe against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_wt_mult_pipe;
  localparam int A_W    = 8;
  localparam int B_W    = 16;
  localparam int P_W    = 24;
  localparam int ACC_W  = 32;
  localparam int SA_W   = 4;
  localparam int SB_W   = 4;
  localparam int SP_W   = 8;
  localparam int SACC_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, sgn, out_valid, out_ready, acc_clr;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic [P_W-1:0]   p;
  logic             s_in_valid, s_in_ready, s_sgn, s_out_valid, s_out_ready, s_acc_clr;
  logic [SA_W-1:0]  s_a;
  logic [SB_W-1:0]  s_b;
  logic [SP_W-1:0]  s_p;
`ifdef WT_ACC_EN
  logic [ACC_W-1:0]  acc;
  logic [SACC_W-1:0] s_acc;
`endif

  wt_mult_pipe #(.A_W(A_W), .B_W(B_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sgn(sgn),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
`ifdef WT_ACC_EN
    , .acc_clr(acc_clr), .acc(acc)
`endif
  );

  wt_mult_pipe #(.A_W(SA_W), .B_W(SB_W)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b), .sgn(s_sgn),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .p(s_p)
`ifdef WT_ACC_EN
    , .acc_clr(s_acc_clr), .acc(s_acc)
`endif
  );

  typedef struct {
    longint         val;
    logic [P_W-1:0] prod;
    logic           clr;
  } exp_t;

  exp_t             exp_q [$];
  logic [P_W-1:0]   got_q [$];
  logic [SP_W-1:0]  s_exp_q [$];
  logic [ACC_W-1:0] acc_m;
  logic [P_W-1:0]   bp_want [4] = '{24'd1, 24'd6, 24'd20, 24'd42};
  int               n_checks = 0;
  int               n_errors = 0;
  int               n_xfer;
  bit               accepted;
  bit               rand_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  function automatic longint ref_val(input logic [A_W-1:0] x, input logic [B_W-1:0] y, input logic s);
    longint xe, ye;
    xe = s ? longint'($signed(x)) : longint'(x);
    ye = s ? longint'($signed(y)) : longint'(y);
    return xe * ye;
  endfunction

  // One clock: handshakes are judged at the falling edge, inputs change 1ns after the rising edge.
  task automatic tick();
    exp_t e;
    bit   xfer;
    xfer     = 1'b0;
    accepted = 1'b0;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    if (out_valid && out_ready) begin
      xfer = 1'b1;
      n_xfer++;
      got_q.push_back(p);
      check("out_has_model_entry", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("p", p, e.prod);
        acc_m = (e.clr ? '0 : acc_m) + ACC_W'(e.val);
      end
    end
    if (in_valid && in_ready) begin
      accepted = 1'b1;
      e.val    = ref_val(a, b, sgn);
      e.prod   = P_W'(e.val);
      e.clr    = acc_clr;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
`ifdef WT_ACC_EN
    if (xfer) check("acc", acc, acc_m);
`endif
  endtask

  // Holds the request until the block takes it; in_valid stays high for back-to-back use.
  task automatic send(input logic [A_W-1:0] x, input logic [B_W-1:0] y, input logic s, input logic c);
    int guard;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    sgn      = s;
    acc_clr  = c;
    guard    = 0;
    do begin
      tick();
      guard++;
    end while (!accepted && guard < 2000);
    check("send_accepted", 64'(accepted), 1);
  endtask

  task automatic drain();
    int guard;
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    guard      = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    sgn        = 1'b0;
    acc_clr    = 1'b0;
    out_ready  = 1'b1;
    rand_ready = 1'b0;
    acc_m      = '0;
    n_xfer     = 0;
    s_in_valid = 1'b0;
    s_a        = '0;
    s_b        = '0;
    s_sgn      = 1'b0;
    s_acc_clr  = 1'b0;
    s_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_p", p, 0);
    check("rst_in_ready", 64'(in_ready), 1);
`ifdef WT_ACC_EN
    check("rst_acc", acc, 0);
`endif

    // Unsigned maximum; out_valid appears on the third edge counting the capture edge.
    send(8'hFF, 16'hFFFF, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("lat_edge1", 64'(out_valid), 0);
    tick();
    check("lat_edge2", 64'(out_valid), 0);
    tick();
    check("lat_edge3", 64'(out_valid), 1);
    check("umax", p, 24'hFEFF01);
    drain();

    // Mixed signed/unsigned stream, one result per cycle.
    send(8'h80, 16'h7FFF, 1'b1, 1'b0);
    send(8'hFF, 16'hFFFF, 1'b1, 1'b0);
    send(8'hFF, 16'hFFFF, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("stream0_valid", 64'(out_valid), 1);
    check("stream0", p, 24'hC00080);
    tick();
    check("stream1_valid", 64'(out_valid), 1);
    check("stream1", p, 24'h000001);
    tick();
    check("stream2_valid", 64'(out_valid), 1);
    check("stream2", p, 24'hFEFF01);
    drain();

    // Backpressure: the fourth pair waits, the head product is held.
    out_ready = 1'b0;
    send(8'd1, 16'd1, 1'b0, 1'b0);
    send(8'd2, 16'd3, 1'b0, 1'b0);
    send(8'd4, 16'd5, 1'b0, 1'b0);
    check("bp_in_ready_low", 64'(in_ready), 0);
    a = 8'd6;
    b = 16'd7;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_no_accept", 64'(accepted), 0);
      check("bp_hold_valid", 64'(out_valid), 1);
      check("bp_hold_p", p, 1);
    end
    got_q.delete();
    out_ready = 1'b1;
    tick();
    check("bp_fourth_accept", 64'(accepted), 1);
    drain();
    check("bp_count", 64'(got_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check("bp_order", got_q[i], bp_want[i]);
    end

    // Reset while three pairs are in flight.
    send(8'd11, 16'd12, 1'b0, 1'b0);
    send(8'd13, 16'd14, 1'b1, 1'b0);
    send(8'd15, 16'd16, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    exp_q.delete();
    acc_m = '0;
    tick();
    rst = 1'b0;
    check("mid_rst_p", p, 0);
    check("mid_rst_in_ready", 64'(in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      check("mid_rst_quiet", 64'(out_valid), 0);
      tick();
    end
    send(8'd3, 16'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    tick();
    check("post_rst_valid", 64'(out_valid), 1);
    check("post_rst_p", p, 9);
    drain();

`ifdef WT_ACC_EN
    send(8'd3, 16'd5, 1'b0, 1'b1);
    send(8'd3, 16'd5, 1'b0, 1'b0);
    send(8'hFF, 16'h0002, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    check("acc_step1", acc, 15);
    tick();
    check("acc_step2", acc, 30);
    tick();
    check("acc_step3", acc, 28);
    drain();
`endif

    // Random sweep with random bubbles and random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      send(A_W'($urandom), B_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end
    drain();

    // Exhaustive 4x4 on the small instance, both modes.
    n_xfer = 0;
    for (int i = 0; i < 512 + 6; i++) begin
      if (i < 512) begin
        s_in_valid = 1'b1;
        s_a        = i[3:0];
        s_b        = i[7:4];
        s_sgn      = i[8];
      end else begin
        s_in_valid = 1'b0;
      end
      @(negedge clk);
      if (s_out_valid && s_out_ready) begin
        n_xfer++;
        check("small_has_entry", 64'(s_exp_q.size() != 0), 1);
        if (s_exp_q.size() != 0) check("small_p", s_p, s_exp_q.pop_front());
      end
      if (s_in_valid && s_in_ready) begin
        longint xe, ye;
        xe = s_sgn ? longint'($signed(s_a)) : longint'(s_a);
        ye = s_sgn ? longint'($signed(s_b)) : longint'(s_b);
        s_exp_q.push_back(SP_W'(xe * ye));
      end
      @(posedge clk);
      #1;
    end
    check("small_count", 64'(n_xfer), 512);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
